// File: rtl/regbank_q_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regbank_q_if                                           |
// | Description : Strobe/data bus between the control decoder, the       |
// |               regbank_q register bank and the output-queue consumer. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface regbank_q_if #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int RW    = (NREGS > 1) ? $clog2(NREGS) : 1
);
    // Decoder strobes and data bus
    logic [WIDTH-1:0]       dbus;
    logic                   load_ir;
    logic                   inc_pc;
    logic                   load_pc;
    logic [1:0]             jump_cond;
    logic                   load_en;
    logic [RW-1:0]          load_sel;
    logic                   flag_en;
    logic                   carry_in;
    logic                   do_out;
    logic                   out_ready;

    // Register bank state and output queue
    logic [WIDTH-1:0]       ir;
    logic [WIDTH-1:0]       pc;
    logic [NREGS*WIDTH-1:0] regs;
    logic                   flag_carry;
    logic                   flag_zero;
    logic                   jump_taken;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_full;
    logic                   out_overflow;

    modport master (
        output dbus, load_ir, inc_pc, load_pc, jump_cond, load_en, load_sel,
               flag_en, carry_in, do_out, out_ready,
        input  ir, pc, regs, flag_carry, flag_zero, jump_taken,
               out_valid, out_data, out_full, out_overflow
    );

    modport slave (
        input  dbus, load_ir, inc_pc, load_pc, jump_cond, load_en, load_sel,
               flag_en, carry_in, do_out, out_ready,
        output ir, pc, regs, flag_carry, flag_zero, jump_taken,
               out_valid, out_data, out_full, out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/regbank_q.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regbank_q                                              |
// | Description : Parametrised register bank: IR, PC, general registers, |
// |               carry/zero flags and a valid/ready output FIFO.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module regbank_q #(
    parameter int WIDTH     = 8,
    parameter int NREGS     = 4,
    parameter int JUMP_REG  = NREGS - 1,
    parameter int OUT_DEPTH = 4
) (
    input  wire logic  clk,
    input  wire logic  reset,
    regbank_q_if.slave bus
);
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [RW:0]   c_NREGS = NREGS[RW:0];
    localparam logic [CW-1:0] c_DEPTH = OUT_DEPTH[CW-1:0];

    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_regs [NREGS];
    logic             r_carry;
    logic             r_zero;
    logic             r_jump;

    logic [WIDTH-1:0] r_mem [OUT_DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;

    logic             w_cond_met;
    logic             w_cond;
    logic             w_sel_ok;
    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_drop;

    // Jump condition decode against the flags held before this edge
    always_comb begin
        w_cond_met = 1'b0;
        case (bus.jump_cond)
            2'd0:    w_cond_met = 1'b1;
            2'd1:    w_cond_met = r_carry;
            2'd2:    w_cond_met = r_zero;
            default: w_cond_met = !r_carry;
        endcase
    end

    assign w_cond    = bus.load_pc && w_cond_met;
    assign w_sel_ok  = ({1'b0, bus.load_sel} < c_NREGS);

    // A full queue can still accept a push when the head leaves in the same cycle
    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == c_DEPTH);
    assign w_pop     = w_valid && bus.out_ready;
    assign w_push_ok = bus.do_out && (!w_full || w_pop);
    assign w_drop    = bus.do_out && w_full && !w_pop;

    // IR, PC, jump indication and flags; jump beats increment
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir    <= '0;
            r_pc    <= '0;
            r_jump  <= 1'b0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_ir   <= bus.load_ir ? bus.dbus : '0;
            r_jump <= w_cond;
            if (w_cond) begin
                r_pc <= r_regs[JUMP_REG];
            end else if (bus.inc_pc) begin
                r_pc <= r_pc + WIDTH'(1);
            end
            if (bus.flag_en) begin
                r_carry <= bus.carry_in;
                r_zero  <= (bus.dbus == '0);
            end
        end
    end

    // General register writes; out-of-range indices are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.load_en && w_sel_ok) begin
            r_regs[bus.load_sel] <= bus.dbus;
        end
    end

    // Queue storage; contents are only observed while the count covers them
    always_ff @(posedge clk) begin
        if (w_push_ok && !reset) begin
            r_mem[r_wptr] <= bus.dbus;
        end
    end

    // Queue pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
            assign bus.regs[gi*WIDTH +: WIDTH] = r_regs[gi];
        end
    endgenerate

    assign bus.ir           = r_ir;
    assign bus.pc           = r_pc;
    assign bus.flag_carry   = r_carry;
    assign bus.flag_zero    = r_zero;
    assign bus.jump_taken   = r_jump;
    assign bus.out_valid    = w_valid;
    assign bus.out_data     = w_valid ? r_mem[r_rptr] : '0;
    assign bus.out_full     = w_full;
    assign bus.out_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_regbank_q.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_regbank_q                                           |
// | Description : Self-checking bench for regbank_q: directed vector     |
// |               table, corner sequences and randomized model checks.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_regbank_q;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int JR = 3;

    logic clk = 1'b0;
    logic reset;
    logic reset3;

    always #5 clk = ~clk;

    regbank_q_if #(.WIDTH(W), .NREGS(N)) bus ();
    regbank_q #(.WIDTH(W), .NREGS(N), .JUMP_REG(JR), .OUT_DEPTH(D)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    regbank_q_if #(.WIDTH(W), .NREGS(3)) bus3 ();
    regbank_q #(.WIDTH(W), .NREGS(3), .JUMP_REG(2), .OUT_DEPTH(D)) u_dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (bus3)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural reference state
    logic [7:0] m_ir, m_pc;
    logic [7:0] m_regs [N];
    logic       m_c, m_z, m_jt, m_ovf;
    logic [7:0] m_q [$];

    typedef struct {
        logic       load_ir, inc_pc, load_pc;
        logic [1:0] jc;
        logic       load_en;
        logic [1:0] sel;
        logic       flag_en, carry_in, do_out, out_ready;
        logic [7:0] dbus;
        logic [7:0] e_ir, e_pc;
        logic       e_jt;
        logic [7:0] e_r3;
        logic       e_c, e_z, e_valid;
        logic [7:0] e_data;
        logic       e_full, e_ovf;
    } vec_t;

    vec_t vecs [26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic ir, inc, ld, input logic [1:0] jc, input logic en, input logic [1:0] sel,
        input logic fe, ci, o, rdy, input logic [7:0] d,
        input logic [7:0] e_ir, e_pc, input logic e_jt, input logic [7:0] e_r3,
        input logic e_c, e_z, e_v, input logic [7:0] e_d, input logic e_f, e_o);
        vec_t v;
        v.load_ir = ir; v.inc_pc = inc; v.load_pc = ld; v.jc = jc; v.load_en = en; v.sel = sel;
        v.flag_en = fe; v.carry_in = ci; v.do_out = o; v.out_ready = rdy; v.dbus = d;
        v.e_ir = e_ir; v.e_pc = e_pc; v.e_jt = e_jt; v.e_r3 = e_r3; v.e_c = e_c; v.e_z = e_z;
        v.e_valid = e_v; v.e_data = e_d; v.e_full = e_f; v.e_ovf = e_o;
        return v;
    endfunction

    task automatic idle();
        bus.dbus = '0; bus.load_ir = 0; bus.inc_pc = 0; bus.load_pc = 0; bus.jump_cond = 0;
        bus.load_en = 0; bus.load_sel = 0; bus.flag_en = 0; bus.carry_in = 0;
        bus.do_out = 0; bus.out_ready = 0;
    endtask

    task automatic drive(input vec_t v);
        bus.load_ir = v.load_ir; bus.inc_pc = v.inc_pc; bus.load_pc = v.load_pc;
        bus.jump_cond = v.jc; bus.load_en = v.load_en; bus.load_sel = v.sel;
        bus.flag_en = v.flag_en; bus.carry_in = v.carry_in; bus.do_out = v.do_out;
        bus.out_ready = v.out_ready; bus.dbus = v.dbus;
    endtask

    task automatic compare_model();
        logic [31:0] flat;
        for (int i = 0; i < N; i++) flat[i*8 +: 8] = m_regs[i];
        chk("ir", 32'(bus.ir), 32'(m_ir));
        chk("pc", 32'(bus.pc), 32'(m_pc));
        chk("regs", bus.regs, flat);
        chk("carry", 32'(bus.flag_carry), 32'(m_c));
        chk("zero", 32'(bus.flag_zero), 32'(m_z));
        chk("jump_taken", 32'(bus.jump_taken), 32'(m_jt));
        chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
        chk("out_data", 32'(bus.out_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        chk("out_full", 32'(bus.out_full), 32'(m_q.size() == D));
        chk("out_overflow", 32'(bus.out_overflow), 32'(m_ovf));
    endtask

    // Advance the model by the rules for the current inputs, clock once, compare
    task automatic step();
        bit taken;
        if (reset) begin
            m_ir = 0; m_pc = 0; m_c = 0; m_z = 0; m_jt = 0; m_ovf = 0;
            for (int i = 0; i < N; i++) m_regs[i] = 0;
            m_q.delete();
        end else begin
            taken = bus.load_pc && (bus.jump_cond == 0 || (bus.jump_cond == 1 && m_c) ||
                    (bus.jump_cond == 2 && m_z) || (bus.jump_cond == 3 && !m_c));
            m_jt = taken;
            if (taken) m_pc = m_regs[JR];
            else if (bus.inc_pc) m_pc = m_pc + 8'd1;
            m_ir = bus.load_ir ? bus.dbus : 8'd0;
            if (bus.load_en && int'(bus.load_sel) < N) m_regs[bus.load_sel] = bus.dbus;
            if (bus.flag_en) begin
                m_c = bus.carry_in;
                m_z = (bus.dbus == 0);
            end
            if (m_q.size() != 0 && bus.out_ready) void'(m_q.pop_front());
            if (bus.do_out) begin
                if (m_q.size() < D) m_q.push_back(bus.dbus);
                else m_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
        compare_model();
    endtask

    initial begin
        // Sequential vector table, starting from reset state
        vecs[0]  = mk(0,0,0,0,1,3,0,0,0,0,8'hFE, 8'h00,8'h00,0,8'hFE,0,0,0,8'h00,0,0);
        vecs[1]  = mk(0,0,1,0,0,0,0,0,0,0,8'h00, 8'h00,8'hFE,1,8'hFE,0,0,0,8'h00,0,0);
        vecs[2]  = mk(0,1,0,0,0,0,0,0,0,0,8'h00, 8'h00,8'hFF,0,8'hFE,0,0,0,8'h00,0,0);
        vecs[3]  = mk(0,1,0,0,0,0,0,0,0,0,8'h00, 8'h00,8'h00,0,8'hFE,0,0,0,8'h00,0,0);
        vecs[4]  = mk(0,1,0,0,0,0,0,0,0,0,8'h00, 8'h00,8'h01,0,8'hFE,0,0,0,8'h00,0,0);
        vecs[5]  = mk(0,0,0,0,1,3,0,0,0,0,8'h40, 8'h00,8'h01,0,8'h40,0,0,0,8'h00,0,0);
        vecs[6]  = mk(0,1,1,0,0,0,0,0,0,0,8'h00, 8'h00,8'h40,1,8'h40,0,0,0,8'h00,0,0);
        vecs[7]  = mk(0,0,0,0,0,0,1,0,0,0,8'h00, 8'h00,8'h40,0,8'h40,0,1,0,8'h00,0,0);
        vecs[8]  = mk(0,1,1,1,0,0,0,0,0,0,8'h00, 8'h00,8'h41,0,8'h40,0,1,0,8'h00,0,0);
        vecs[9]  = mk(0,0,1,2,0,0,0,0,0,0,8'h00, 8'h00,8'h40,1,8'h40,0,1,0,8'h00,0,0);
        vecs[10] = mk(0,0,0,0,1,3,0,0,0,0,8'h11, 8'h00,8'h40,0,8'h11,0,1,0,8'h00,0,0);
        vecs[11] = mk(0,0,1,3,1,3,0,0,0,0,8'h22, 8'h00,8'h11,1,8'h22,0,1,0,8'h00,0,0);
        vecs[12] = mk(0,0,1,3,0,0,0,0,0,0,8'h00, 8'h00,8'h22,1,8'h22,0,1,0,8'h00,0,0);
        vecs[13] = mk(1,0,0,0,0,0,1,1,0,0,8'h05, 8'h05,8'h22,0,8'h22,1,0,0,8'h00,0,0);
        vecs[14] = mk(0,1,1,3,0,0,0,0,0,0,8'h00, 8'h00,8'h23,0,8'h22,1,0,0,8'h00,0,0);
        vecs[15] = mk(0,0,1,1,0,0,0,0,0,0,8'h00, 8'h00,8'h22,1,8'h22,1,0,0,8'h00,0,0);
        vecs[16] = mk(0,1,1,2,0,0,0,0,0,0,8'h00, 8'h00,8'h23,0,8'h22,1,0,0,8'h00,0,0);
        vecs[17] = mk(0,0,0,0,0,0,0,0,1,0,8'h01, 8'h00,8'h23,0,8'h22,1,0,1,8'h01,0,0);
        vecs[18] = mk(0,0,0,0,0,0,0,0,1,0,8'h02, 8'h00,8'h23,0,8'h22,1,0,1,8'h01,0,0);
        vecs[19] = mk(0,0,0,0,0,0,0,0,1,0,8'h03, 8'h00,8'h23,0,8'h22,1,0,1,8'h01,0,0);
        vecs[20] = mk(0,0,0,0,0,0,0,0,1,0,8'h04, 8'h00,8'h23,0,8'h22,1,0,1,8'h01,1,0);
        vecs[21] = mk(0,0,0,0,0,0,0,0,1,0,8'h05, 8'h00,8'h23,0,8'h22,1,0,1,8'h01,1,1);
        vecs[22] = mk(0,0,0,0,0,0,0,0,0,1,8'h00, 8'h00,8'h23,0,8'h22,1,0,1,8'h02,0,1);
        vecs[23] = mk(0,0,0,0,0,0,0,0,0,1,8'h00, 8'h00,8'h23,0,8'h22,1,0,1,8'h03,0,1);
        vecs[24] = mk(0,0,0,0,0,0,0,0,0,1,8'h00, 8'h00,8'h23,0,8'h22,1,0,1,8'h04,0,1);
        vecs[25] = mk(0,0,0,0,0,0,0,0,0,1,8'h00, 8'h00,8'h23,0,8'h22,1,0,0,8'h00,0,1);

        reset3 = 1'b1;
        bus3.dbus = '0; bus3.load_ir = 0; bus3.inc_pc = 0; bus3.load_pc = 0; bus3.jump_cond = 0;
        bus3.load_en = 0; bus3.load_sel = 0; bus3.flag_en = 0; bus3.carry_in = 0;
        bus3.do_out = 0; bus3.out_ready = 0;

        // Reset wins over every strobe
        reset = 1'b1;
        bus.dbus = 8'hFF; bus.load_ir = 1; bus.inc_pc = 1; bus.load_pc = 1; bus.jump_cond = 0;
        bus.load_en = 1; bus.load_sel = 2'd3; bus.flag_en = 1; bus.carry_in = 1;
        bus.do_out = 1; bus.out_ready = 1;
        step();
        chk("rst_ir", 32'(bus.ir), 0);
        chk("rst_pc", 32'(bus.pc), 0);
        chk("rst_regs", bus.regs, 0);
        chk("rst_flags", {30'd0, bus.flag_carry, bus.flag_zero}, 0);
        chk("rst_jt", 32'(bus.jump_taken), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_full_ovf", {30'd0, bus.out_full, bus.out_overflow}, 0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k]);
            step();
            chk($sformatf("v%0d_ir", k), 32'(bus.ir), 32'(vecs[k].e_ir));
            chk($sformatf("v%0d_pc", k), 32'(bus.pc), 32'(vecs[k].e_pc));
            chk($sformatf("v%0d_jt", k), 32'(bus.jump_taken), 32'(vecs[k].e_jt));
            chk($sformatf("v%0d_r3", k), 32'(bus.regs[31:24]), 32'(vecs[k].e_r3));
            chk($sformatf("v%0d_cz", k), {30'd0, bus.flag_carry, bus.flag_zero},
                {30'd0, vecs[k].e_c, vecs[k].e_z});
            chk($sformatf("v%0d_valid", k), 32'(bus.out_valid), 32'(vecs[k].e_valid));
            chk($sformatf("v%0d_data", k), 32'(bus.out_data), 32'(vecs[k].e_data));
            chk($sformatf("v%0d_full", k), 32'(bus.out_full), 32'(vecs[k].e_full));
            chk($sformatf("v%0d_ovf", k), 32'(bus.out_overflow), 32'(vecs[k].e_ovf));
        end

        // Push and pop together while full: no drop, order preserved
        idle(); reset = 1'b1; step(); reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idle(); bus.do_out = 1; bus.dbus = 8'(i); step();
        end
        chk("pp_full_before", 32'(bus.out_full), 1);
        idle(); bus.do_out = 1; bus.dbus = 8'h09; bus.out_ready = 1; step();
        chk("pp_full_after", 32'(bus.out_full), 1);
        chk("pp_ovf", 32'(bus.out_overflow), 0);
        chk("pp_head2", 32'(bus.out_data), 32'h02);
        idle(); bus.out_ready = 1; step();
        chk("pp_head3", 32'(bus.out_data), 32'h03);
        step();
        chk("pp_head4", 32'(bus.out_data), 32'h04);
        step();
        chk("pp_head9", 32'(bus.out_data), 32'h09);
        step();
        chk("pp_empty", {31'd0, bus.out_valid}, 0);

        // Reset in the middle of a burst discards the queue
        idle(); bus.do_out = 1; bus.dbus = 8'hAA; step();
        bus.dbus = 8'hBB; step();
        reset = 1'b1; step();
        chk("midrst_valid", 32'(bus.out_valid), 0);
        chk("midrst_data", 32'(bus.out_data), 0);
        reset = 1'b0; idle(); step();

        // Three-register variant: an out-of-range index writes nothing
        reset3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus3.load_en = 1; bus3.load_sel = 2'(i); bus3.dbus = 8'hA1 + 8'(i * 17);
            step();
        end
        chk("n3_regs", 32'(bus3.regs), 32'hC3B2A1);
        bus3.load_sel = 2'd3; bus3.dbus = 8'hEE; step();
        chk("n3_oob", 32'(bus3.regs), 32'hC3B2A1);
        bus3.load_en = 0;

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(0, 49) == 0);
            bus.dbus      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            bus.load_ir   = 1'($urandom);
            bus.inc_pc    = 1'($urandom);
            bus.load_pc   = ($urandom_range(0, 3) == 0);
            bus.jump_cond = 2'($urandom);
            bus.load_en   = 1'($urandom);
            bus.load_sel  = 2'($urandom);
            bus.flag_en   = 1'($urandom);
            bus.carry_in  = 1'($urandom);
            bus.do_out    = ($urandom_range(0, 9) < 6);
            bus.out_ready = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regbank_q.md
Name: regbank_q

Overview:
- Parametrised successor of the nic8 register bank, for the wider CPU variants.
- Holds IR, PC, NREGS general registers, carry/zero flags and an output queue.
- The output queue replaces the single Q latch: a FIFO drained by a valid/ready consumer, so OUT bursts are not lost.
- Sits between the control decoder (strobes) and the data bus; all state is updated on the rising edge of clk.

Parameters:
WIDTH, 8, datapath width of dbus, IR, PC, registers, queue entries
NREGS, 4, number of general registers (>=2); register index width RW = max(1, clog2(NREGS))
JUMP_REG, NREGS-1, index of the register supplying the jump target
OUT_DEPTH, 4, output FIFO depth (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dbus  in  WIDTH  data bus value for this cycle
load_ir  in  1  capture dbus into IR
inc_pc  in  1  increment PC
load_pc  in  1  jump request
jump_cond  in  2  0=always, 1=carry set, 2=zero set, 3=carry clear
load_en  in  1  write a general register
load_sel  in  RW  register index for load_en
flag_en  in  1  update flags
carry_in  in  1  ALU carry-out
do_out  in  1  push dbus into the output FIFO
out_ready  in  1  consumer accepts the head entry
ir  out  WIDTH  instruction register
pc  out  WIDTH  program counter
regs  out  NREGS*WIDTH  flattened registers; reg i at [i*WIDTH +: WIDTH]
flag_carry  out  1  carry flag
flag_zero  out  1  zero flag
jump_taken  out  1  registered: PC was loaded from JUMP_REG on the last edge
out_valid  out  1  FIFO non-empty
out_data  out  WIDTH  FIFO head; 0 when empty
out_full  out  1  FIFO holds OUT_DEPTH entries
out_overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset (synchronous, takes priority over every strobe): all outputs, registers, flags and FIFO pointers/count go to 0; out_valid=0, out_full=0, out_overflow=0.
- All loads have one-cycle latency: a value strobed at edge N is visible after edge N.
- IR: ir <= load_ir ? dbus : 0. IR clears on any cycle without load_ir (fetch-bubble semantics).
- Jump condition:
  - cond = load_pc && (jump_cond==0 || (1 && flag_carry) || (2 && flag_zero) || (3 && !flag_carry)).
  - Flags used are the registered values from before this edge.
- PC priority:
  - cond: pc <= regs[JUMP_REG], using the pre-edge value even if that register is written this cycle.
  - else inc_pc: pc <= pc+1, wrapping modulo 2^WIDTH.
  - else pc holds.
- jump_taken <= cond each cycle.
- General registers:
  - load_en && load_sel<NREGS: regs[load_sel] <= dbus.
  - load_sel>=NREGS: write ignored.
- Flags: when flag_en, flag_carry <= carry_in and flag_zero <= (dbus==0); otherwise both hold.
- FIFO:
  - push = do_out; pop = out_valid && out_ready.
  - Pop only: remove the head.
  - Push while not full: append dbus.
  - Push while full without pop: dbus dropped, out_overflow <= 1 until reset.
  - Push and pop while full: both succeed, count unchanged, no overflow.
  - Push and pop while empty: push succeeds; pop is not possible since out_valid=0.
  - Pointers wrap modulo OUT_DEPTH. Count is 0..OUT_DEPTH.
  - out_valid = count!=0; out_full = count==OUT_DEPTH.
  - Ordering is strict FIFO.
- Reset asserted mid-burst: FIFO contents are discarded, out_valid=0 on the following cycle.

Test Plan:
- Reset: hold reset with all strobes high and dbus=8'hFF -> after the edge every output is 0, out_valid=0, out_overflow=0.
- Increment and wrap: pc=8'hFE, inc_pc for 3 cycles -> pc goes FF, 00, 01; inc_pc with unconditional load_pc and reg3=8'h40 -> pc=40, jump_taken=1 (jump wins).
- Conditional jumps:
  - flag_en, carry_in=0, dbus=0 -> carry=0, zero=1.
  - load_pc with jump_cond=1 -> pc increments only, jump_taken=0.
  - jump_cond=2 -> pc=reg3.
  - jump_cond=3 -> taken.
- Register write hazard: load_en sel=3 dbus=8'h22 in the same cycle as a taken jump, reg3 previously 8'h11 -> pc=11, reg3=22. Write with load_sel>=NREGS (NREGS=3) -> no register changes.
- FIFO fill/overflow (OUT_DEPTH=4, out_ready=0):
  - Push 1,2,3,4 -> out_full=1.
  - Push 5 -> dropped, out_overflow=1.
  - Then out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, then out_valid=0, out_data=0.
- Simultaneous push/pop when full: full with 1..4, push 9 with out_ready=1 -> count stays 4, out_overflow stays 0, drain order 2,3,4,9.
